// File: rtl/mem_arbiter_pkg.sv
// Shared constants and FSM encoding for the cache-to-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

   localparam int WORD_SIZE = 32;
   localparam int LINE_SIZE = 128;
   localparam int MAX_WAIT  = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IC = 2'd1,
      BUSY_DC = 2'd2,
      RESP    = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: bit0 = iCache, bit1 = dCache, one-hot grant.
// Latency: combinational.
// Backpressure: none; a tie goes to whichever side was not served last.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_dc,
   output logic [1:0] grant
);

   // Single requester wins outright; a tie alternates on last_dc.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11)
         grant = last_dc ? 2'b01 : 2'b10;
      else
         grant = req;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates iCache fills and dCache fills/write-backs onto one line-wide memory port.
// Latency: grant 1 cycle, memory latency, then RESP and a 1-cycle ready pulse (mem latency + 3).
// Backpressure: requesters hold req until ready; mem_read/mem_write held until mem_ready or timeout.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = mem_arbiter_pkg::WORD_SIZE,
   parameter int LINE_SIZE = mem_arbiter_pkg::LINE_SIZE,
   parameter int MAX_WAIT  = mem_arbiter_pkg::MAX_WAIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ic_req,
   input  logic [WORD_SIZE-1:0] ic_addr,
   output logic                 ic_ready,
   output logic [LINE_SIZE-1:0] ic_line,
   input  logic                 dc_req,
   input  logic                 dc_we,
   input  logic [WORD_SIZE-1:0] dc_addr,
   input  logic [LINE_SIZE-1:0] dc_wline,
   output logic                 dc_ready,
   output logic [LINE_SIZE-1:0] dc_line,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [LINE_SIZE-1:0] mem_wline,
   input  logic                 mem_ready,
   input  logic [LINE_SIZE-1:0] mem_line,
   output logic                 timeout
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   // Lines are 16 bytes, so the low nibble of every memory address is zero.
   localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(32'hF);

   state_t               state;
   logic                 serve_dc;
   logic                 last_dc;
   logic [WORD_SIZE-1:0] addr_q;
   logic [LINE_SIZE-1:0] wline_q;
   logic [LINE_SIZE-1:0] line_q;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [1:0]           req_vec;
   logic [1:0]           grant;

   // A requester still high during its own ready pulse is masked for one cycle.
   assign req_vec = {dc_req & ~dc_ready, ic_req & ~ic_ready};

   rr_arbiter2 u_rr (
      .req     (req_vec),
      .last_dc (last_dc),
      .grant   (grant)
   );

   // Memory port only ever reflects values latched at grant time.
   assign mem_addr  = addr_q;
   assign mem_wline = wline_q;

   // Arbiter FSM with registered outputs: grant, memory wait, respond.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         serve_dc  <= 1'b0;
         last_dc   <= 1'b0;
         addr_q    <= '0;
         wline_q   <= '0;
         line_q    <= '0;
         wait_cnt  <= '0;
         ic_ready  <= 1'b0;
         dc_ready  <= 1'b0;
         ic_line   <= '0;
         dc_line   <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         ic_ready <= 1'b0;
         dc_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant[1]) begin
                  state     <= BUSY_DC;
                  serve_dc  <= 1'b1;
                  addr_q    <= dc_addr & ALIGN_MASK;
                  wline_q   <= dc_wline;
                  mem_write <= dc_we;
                  mem_read  <= ~dc_we;
                  wait_cnt  <= '0;
               end else if (grant[0]) begin
                  state     <= BUSY_IC;
                  serve_dc  <= 1'b0;
                  addr_q    <= ic_addr & ALIGN_MASK;
                  wline_q   <= '0;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  wait_cnt  <= '0;
               end
            end
            BUSY_IC, BUSY_DC: begin
               if (mem_ready) begin
                  line_q    <= mem_line;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= RESP;
               end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                  // Memory gave up on: drop the request and answer with an empty line.
                  wait_cnt  <= WAIT_W'(MAX_WAIT);
                  timeout   <= 1'b1;
                  line_q    <= '0;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            RESP: begin
               if (serve_dc) begin
                  dc_ready <= 1'b1;
                  dc_line  <= line_q;
               end else begin
                  ic_ready <= 1'b1;
                  ic_line  <= line_q;
               end
               last_dc <= serve_dc;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
